// File: rtl/snail_test_sequencer.sv
// Self-test run controller for the snail recognizer chain: plays a latched
// pattern serially on a divided step strobe and counts detections per run.
module snail_test_sequencer #(
    parameter int div_width   = 24,
    parameter int count_width = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [7:0]             pattern,
    input  logic [2:0]             len,
    input  logic                   repeat_mode,
    input  logic [div_width-1:0]   period,
    input  logic                   moore_y,
    input  logic                   mealy_y,
    output logic                   en,
    output logic                   seq_bit,
    output logic                   busy,
    output logic                   done,
    output logic [count_width-1:0] moore_cnt,
    output logic [count_width-1:0] mealy_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t                 state_q, state_d;
    logic [7:0]             pat_q, pat_d;
    logic [2:0]             len_q, len_d;
    logic                   rep_q, rep_d;
    logic [div_width-1:0]   per_q, per_d;
    logic [div_width-1:0]   div_q, div_d;
    logic [2:0]             idx_q, idx_d;
    logic [count_width-1:0] moore_q, moore_d;
    logic [count_width-1:0] mealy_q, mealy_d;

    assign busy      = (state_q == RUN);
    assign done      = (state_q == FIN);
    assign en        = busy && (div_q == per_q);
    assign seq_bit   = busy && pat_q[idx_q];
    assign moore_cnt = moore_q;
    assign mealy_cnt = mealy_q;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        rep_d   = rep_q;
        per_d   = per_q;
        div_d   = div_q;
        idx_d   = idx_q;
        moore_d = moore_q;
        mealy_d = mealy_q;
        unique case (state_q)
            IDLE: begin
                // abort takes priority over a coincident start
                if (start && !abort) begin
                    state_d = RUN;
                    pat_d   = pattern;
                    len_d   = len;
                    rep_d   = repeat_mode;
                    per_d   = period;
                    div_d   = '0;
                    idx_d   = '0;
                    moore_d = '0;
                    mealy_d = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (en) begin
                    div_d = '0;
                    if (moore_y && (moore_q != '1)) moore_d = moore_q + 1'b1;
                    if (mealy_y && (mealy_q != '1)) mealy_d = mealy_q + 1'b1;
                    if (idx_q == len_q) begin
                        idx_d = '0;
                        if (!rep_q) state_d = FIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            rep_q   <= 1'b0;
            per_q   <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            moore_q <= '0;
            mealy_q <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            per_q   <= per_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            moore_q <= moore_d;
            mealy_q <= mealy_d;
        end
    end

endmodule

// File: tb/tb_snail_test_sequencer.sv
// Directed bench for snail_test_sequencer: a default-width instance plus a
// 3-bit-counter instance sharing the same stimulus.
module tb_snail_test_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  pattern = 8'h00;
    logic [2:0]  len = 3'd0;
    logic        repeat_mode = 1'b0;
    logic [23:0] period = 24'd0;
    logic        moore_y = 1'b0;
    logic        mealy_mode = 1'b0;
    logic        mealy_y;

    logic       en, seq_bit, busy, done;
    logic [7:0] moore_cnt, mealy_cnt;
    logic       en_s, seq_bit_s, busy_s, done_s;
    logic [2:0] moore_cnt_s, mealy_cnt_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign mealy_y = mealy_mode & seq_bit;

    snail_test_sequencer #(.div_width(24), .count_width(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .pattern(pattern), .len(len), .repeat_mode(repeat_mode),
        .period(period), .moore_y(moore_y), .mealy_y(mealy_y),
        .en(en), .seq_bit(seq_bit), .busy(busy), .done(done),
        .moore_cnt(moore_cnt), .mealy_cnt(mealy_cnt)
    );

    snail_test_sequencer #(.div_width(24), .count_width(3)) dut_s (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .pattern(pattern), .len(len), .repeat_mode(repeat_mode),
        .period(period), .moore_y(moore_y), .mealy_y(mealy_y),
        .en(en_s), .seq_bit(seq_bit_s), .busy(busy_s), .done(done_s),
        .moore_cnt(moore_cnt_s), .mealy_cnt(mealy_cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [7:0] p, input logic [2:0] l,
                          input logic r, input logic [23:0] per);
        @(negedge clk);
        pattern     = p;
        len         = l;
        repeat_mode = r;
        period      = per;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    initial begin
        logic [19:0] en_mask;
        logic [3:0]  bits4;
        logic [11:0] bits12;
        int          nbit, nbusy, ndone, done_at, nen;
        logic        any_done;

        // reset and idle
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_en", en, 0);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_seq", seq_bit, 0);
        chk("idle_moore", moore_cnt, 0);
        chk("idle_mealy", mealy_cnt, 0);

        // single pass, with late input changes and a start during RUN
        moore_y    = 1'b1;
        mealy_mode = 1'b1;
        launch(8'b0000_1101, 3'd3, 1'b0, 24'd2);
        en_mask = '0; bits4 = '0; nbit = 0;
        nbusy = 0; ndone = 0; done_at = -1;
        for (int c = 0; c < 20; c++) begin
            if (en) begin
                en_mask[c] = 1'b1;
                if (nbit < 4) bits4[nbit] = seq_bit;
                nbit++;
            end
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            start   = (c == 4);
            pattern = (c >= 1) ? 8'hFF : 8'b0000_1101;
            @(negedge clk);
        end
        start = 1'b0;
        chk("sp_en_mask", en_mask, 20'h00924);
        chk("sp_en_count", nbit, 4);
        chk("sp_seq_bits", bits4, 4'b1101);
        chk("sp_busy_len", nbusy, 12);
        chk("sp_done_cnt", ndone, 1);
        chk("sp_done_at", done_at, 12);
        chk("sp_moore", moore_cnt, 4);
        chk("sp_mealy", mealy_cnt, 3);
        chk("sp_moore_s", moore_cnt_s, 4);
        chk("sp_idle_busy", busy, 0);

        // repeat mode, then abort
        launch(8'b0000_0010, 3'd1, 1'b1, 24'd0);
        bits12 = '0; nen = 0;
        for (int c = 0; c < 12; c++) begin
            bits12[c] = seq_bit;
            if (en) nen++;
            @(negedge clk);
        end
        chk("rp_seq_bits", bits12, 12'hAAA);
        chk("rp_en_count", nen, 12);
        chk("rp_busy", busy, 1);
        chk("rp_moore", moore_cnt, 12);
        chk("rp_mealy", mealy_cnt, 6);
        chk("rp_moore_sat", moore_cnt_s, 7);
        chk("rp_mealy_s", mealy_cnt_s, 6);
        moore_y    = 1'b0;
        mealy_mode = 1'b0;
        abort      = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_en", en, 0);
        any_done = done;
        repeat (3) begin
            @(negedge clk);
            any_done = any_done | done;
        end
        chk("ab_no_done", any_done, 0);
        chk("ab_moore", moore_cnt, 12);
        chk("ab_mealy", mealy_cnt, 6);
        chk("ab_moore_s", moore_cnt_s, 7);

        // start + abort in IDLE: abort wins, counters untouched
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", busy, 0);
        @(negedge clk);
        chk("sa_busy2", busy, 0);
        chk("sa_moore", moore_cnt, 12);

        // asynchronous reset mid-run
        moore_y = 1'b1;
        launch(8'hFF, 3'd7, 1'b1, 24'd3);
        repeat (5) @(negedge clk);
        chk("mr_busy", busy, 1);
        chk("mr_seq", seq_bit, 1);
        chk("mr_moore", moore_cnt, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_en", en, 0);
        chk("ar_seq", seq_bit, 0);
        chk("ar_done", done, 0);
        chk("ar_moore", moore_cnt, 0);
        chk("ar_mealy", mealy_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("ar_idle_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
